// File: rtl/blackjack_clk_pkg.sv
// blackjack_clk_pkg: level limits, speed-controller FSM states, level -> {slow, turbo} map
package blackjack_clk_pkg;
  localparam logic [2:0] LVL_MIN = 3'd0;
  localparam logic [2:0] LVL_MAX = 3'd4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd1, ST_DONE = 2'd2} state_e;
  function automatic logic [2:0] lvl_map(input logic [2:0] l);
    return (l == LVL_MIN) ? 3'b100 : {1'b0, 2'(l - 3'd1)};
  endfunction
endpackage

// File: rtl/divider_speed_ctrl_if.sv
// divider_speed_ctrl_if: deal burst handshake; master = game FSM (req, len), slave = speed controller (ack, busy, done)
interface divider_speed_ctrl_if;
  logic       deal_req;
  logic [7:0] deal_len;
  logic       deal_ack;
  logic       deal_busy;
  logic       deal_done;
  modport master (output deal_req, deal_len, input deal_ack, deal_busy, deal_done);
  modport slave  (input deal_req, deal_len, output deal_ack, deal_busy, deal_done);
endinterface

// File: rtl/divider_speed_ctrl_btn_debounce.sv
// btn_debounce: 2-flop sync + stable-count debounce of i_btn, o_press pulses on accepted 0->1 (clk_in, reset_n)
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_press
);
  logic        r_s1, r_s2, r_state;
  logic [15:0] r_cnt;
  logic        w_diff, w_flip;
  assign w_diff = r_s2 != r_state;
  assign w_flip = w_diff && (r_cnt == DEBOUNCE_CYCLES - 16'd1);
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= 16'd0;
      o_press <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_cnt   <= (w_diff && !w_flip) ? r_cnt + 16'd1 : 16'd0;
      r_state <= r_state ^ w_flip;
      o_press <= w_flip && r_s2;
    end
endmodule

// File: rtl/divider_speed_ctrl.sv
// divider_speed_ctrl: button level stepping + deal-burst override of divider turbo/slow (clk_in, reset_n, btn_up/down, tick, deal if, turbo, slow, level)
module divider_speed_ctrl
  import blackjack_clk_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [2:0]  DEFAULT_LEVEL   = 3'd1,
  parameter logic [2:0]  BURST_LEVEL     = 3'd4
) (
  input  logic                        clk_in,
  input  logic                        reset_n,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        tick,
  divider_speed_ctrl_if.slave         deal,
  output logic [1:0]                  turbo,
  output logic                        slow,
  output logic [2:0]                  level
);
  state_e     r_state, w_nxt;
  logic [2:0] r_level, w_level_nxt, r_map;
  logic [7:0] r_cnt, r_len, w_cnt;
  logic       r_tick_d, r_ack, r_busy, r_done;
  logic       w_up, w_dn, w_rise, w_hit, w_ovr;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (.clk_in, .reset_n, .i_btn(btn_up),   .o_press(w_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (.clk_in, .reset_n, .i_btn(btn_down), .o_press(w_dn));
  assign w_level_nxt = (w_up && !w_dn && r_level != LVL_MAX) ? r_level + 3'd1 :
                       (w_dn && !w_up && r_level != LVL_MIN) ? r_level - 3'd1 : r_level;
  assign w_rise = tick && !r_tick_d;
  assign w_cnt  = r_cnt + {7'd0, w_rise};
  // r_cnt == r_len only holds for a zero length, which must exit on the first burst cycle
  assign w_hit  = (r_cnt == r_len) || (w_cnt == r_len);
  assign w_nxt  = (r_state == ST_IDLE)  ? (deal.deal_req ? ST_BURST : ST_IDLE) :
                  (r_state == ST_BURST) ? (w_hit ? ST_DONE : ST_BURST) : ST_IDLE;
  // DONE still shows the burst outputs; done/busy/map flip together on the DONE -> IDLE edge
  assign w_ovr  = w_nxt != ST_IDLE;
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_level  <= DEFAULT_LEVEL;
      r_map    <= lvl_map(DEFAULT_LEVEL);
      r_cnt    <= 8'd0;
      r_len    <= 8'd0;
      r_tick_d <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_level  <= w_level_nxt;
      r_map    <= lvl_map(w_ovr ? BURST_LEVEL : w_level_nxt);
      r_cnt    <= (r_state == ST_BURST) ? w_cnt : 8'd0;
      r_len    <= (r_state == ST_IDLE && deal.deal_req) ? deal.deal_len : r_len;
      r_tick_d <= tick;
      r_ack    <= r_state == ST_IDLE && deal.deal_req;
      r_busy   <= w_ovr;
      r_done   <= r_state == ST_DONE;
    end
  assign level          = r_level;
  assign {slow, turbo}  = r_map;
  assign deal.deal_ack  = r_ack;
  assign deal.deal_busy = r_busy;
  assign deal.deal_done = r_done;
endmodule

// File: tb/tb_divider_speed_ctrl.sv
// tb_divider_speed_ctrl: table vectors, hand corner sequences and random ops against a behavioural model
module tb_divider_speed_ctrl;
  logic       clk_in = 1'b0;
  logic       reset_n, btn_up, btn_down, tick;
  logic [1:0] turbo;
  logic       slow;
  logic [2:0] level;
  int         n_chk = 0, n_pass = 0, m_level;
  bit   [2:0] lvl_tab [5] = '{3'b100, 3'b000, 3'b001, 3'b010, 3'b011};
  typedef struct { bit up; bit dn; int lvl; bit sl; bit [1:0] tb; } vec_t;
  vec_t vt [14];
  divider_speed_ctrl_if dif ();
  divider_speed_ctrl #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk_in, .reset_n, .btn_up, .btn_down, .tick, .deal(dif.slave), .turbo, .slow, .level);
  always #5 clk_in = ~clk_in;
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic chk_map(input string name, input int l);
    bit [2:0] m;
    m = lvl_tab[l];
    chk({name, "_slow"}, int'(slow), int'(m[2]));
    chk({name, "_turbo"}, int'(turbo), int'(m[1:0]));
  endtask
  task automatic chk_hs(input string name, input int a, input int b, input int d);
    chk({name, "_ack"}, int'(dif.deal_ack), a);
    chk({name, "_busy"}, int'(dif.deal_busy), b);
    chk({name, "_done"}, int'(dif.deal_done), d);
  endtask
  task automatic press(input bit up, input bit dn);
    btn_up = up;
    btn_down = dn;
    repeat (6) step();
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (12) step();
  endtask
  task automatic burst_rand();
    int len, rises, jj;
    bit prev;
    bit tw[$];
    len = $urandom_range(0, 6);
    prev = 1'b0;
    rises = 0;
    jj = -1;
    for (int j = 0; jj < 0; j++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      tw.push_back(b);
      if (b && !prev) rises++;
      prev = b;
      if (rises >= len) jj = j;
    end
    tick = 1'b0;
    dif.deal_req = 1'b1;
    dif.deal_len = 8'(len);
    step();
    chk_hs("rnd_grant", 1, 1, 0);
    chk_map("rnd_grant", 4);
    for (int j = 0; j <= jj + 1; j++) begin
      tick = (j <= jj) ? tw[j] : 1'b0;
      dif.deal_req = 1'($urandom_range(0, 1));
      dif.deal_len = 8'($urandom);
      step();
      if (j <= jj) begin
        chk_hs("rnd_burst", 0, 1, 0);
        chk_map("rnd_burst", 4);
      end else begin
        chk_hs("rnd_end", 0, 0, 1);
        chk_map("rnd_end", m_level);
      end
    end
    dif.deal_req = 1'b0;
    tick = 1'b0;
    step();
    chk_hs("rnd_after", 0, 0, 0);
  endtask
  initial begin
    vt[0]  = '{1, 0, 2, 0, 2'b01};
    vt[1]  = '{1, 0, 3, 0, 2'b10};
    vt[2]  = '{1, 0, 4, 0, 2'b11};
    vt[3]  = '{1, 0, 4, 0, 2'b11};
    vt[4]  = '{1, 0, 4, 0, 2'b11};
    vt[5]  = '{0, 1, 3, 0, 2'b10};
    vt[6]  = '{0, 1, 2, 0, 2'b01};
    vt[7]  = '{0, 1, 1, 0, 2'b00};
    vt[8]  = '{0, 1, 0, 1, 2'b00};
    vt[9]  = '{0, 1, 0, 1, 2'b00};
    vt[10] = '{0, 1, 0, 1, 2'b00};
    vt[11] = '{1, 0, 1, 0, 2'b00};
    vt[12] = '{1, 1, 1, 0, 2'b00};
    vt[13] = '{1, 0, 2, 0, 2'b01};
    reset_n = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick = 1'b0;
    dif.deal_req = 1'b0;
    dif.deal_len = 8'd0;
    repeat (3) step();
    chk("rst_level", int'(level), 1);
    chk_map("rst", 1);
    chk_hs("rst", 0, 0, 0);
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      press(vt[i].up, vt[i].dn);
      chk($sformatf("vec%0d_level", i), int'(level), vt[i].lvl);
      chk($sformatf("vec%0d_slow", i), int'(slow), int'(vt[i].sl));
      chk($sformatf("vec%0d_turbo", i), int'(turbo), int'(vt[i].tb));
    end
    btn_up = 1'b1;
    repeat (3) step();
    btn_up = 1'b0;
    repeat (12) step();
    chk("glitch_level", int'(level), 2);
    dif.deal_req = 1'b1;
    dif.deal_len = 8'd3;
    tick = 1'b1;
    step();
    chk_hs("b3_grant", 1, 1, 0);
    chk_map("b3_grant", 4);
    dif.deal_req = 1'b0;
    tick = 1'b0;
    btn_up = 1'b1;
    repeat (6) step();
    chk("b3_level_pre", int'(level), 2);
    btn_up = 1'b0;
    step();
    chk("b3_level_press", int'(level), 3);
    chk_map("b3_hold", 4);
    chk_hs("b3_hold", 0, 1, 0);
    repeat (10) step();
    dif.deal_req = 1'b1;
    for (int p = 0; p < 3; p++) begin
      tick = 1'b1;
      step();
      chk_hs("b3_tick", 0, 1, 0);
      chk_map("b3_tick", 4);
      tick = 1'b0;
      if (p == 2) begin
        dif.deal_req = 1'b0;
        step();
        chk_hs("b3_end", 0, 0, 1);
        chk_map("b3_end", 3);
      end else
        repeat (3) begin
          step();
          chk_hs("b3_gap", 0, 1, 0);
        end
    end
    step();
    chk_hs("b3_after", 0, 0, 0);
    dif.deal_req = 1'b1;
    dif.deal_len = 8'd0;
    step();
    chk_hs("b0_grant", 1, 1, 0);
    dif.deal_req = 1'b0;
    step();
    chk_hs("b0_mid", 0, 1, 0);
    chk_map("b0_mid", 4);
    step();
    chk_hs("b0_end", 0, 0, 1);
    chk_map("b0_end", 3);
    btn_up = 1'b1;
    repeat (6) step();
    chk("lat6_level", int'(level), 3);
    btn_up = 1'b0;
    step();
    chk("lat7_level", int'(level), 4);
    repeat (12) step();
    dif.deal_req = 1'b1;
    dif.deal_len = 8'd200;
    step();
    chk_hs("rb_grant", 1, 1, 0);
    dif.deal_req = 1'b0;
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    chk("rb_level", int'(level), 1);
    chk_map("rb", 1);
    chk_hs("rb", 0, 0, 0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (5) begin
      step();
      chk_hs("rb_post", 0, 0, 0);
    end
    m_level = 1;
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 2) burst_rand();
      else begin
        press(op == 0, op == 1);
        m_level = (op == 0) ? ((m_level < 4) ? m_level + 1 : 4) : ((m_level > 0) ? m_level - 1 : 0);
        chk("rnd_level", int'(level), m_level);
        chk_map("rnd_press", m_level);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
